// File: rtl/sram_async_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_async_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WR_HOLD,
      ST_READ,
      ST_TURN
   } state_t;

   localparam logic STROBE_OFF = 1'b1;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Active-low {g,f,e,d,c,b,a} patterns for a hex digit.
   function automatic logic [6:0] seg7_pattern(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = 7'b1000000;
         4'h1:    p = 7'b1111001;
         4'h2:    p = 7'b0100100;
         4'h3:    p = 7'b0110000;
         4'h4:    p = 7'b0011001;
         4'h5:    p = 7'b0010010;
         4'h6:    p = 7'b0000010;
         4'h7:    p = 7'b1111000;
         4'h8:    p = 7'b0000000;
         4'h9:    p = 7'b0010000;
         4'hA:    p = 7'b0001000;
         4'hB:    p = 7'b0000011;
         4'hC:    p = 7'b1000110;
         4'hD:    p = 7'b0100001;
         4'hE:    p = 7'b0000110;
         default: p = 7'b0001110;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sram_async_ctrl_if.sv
// User-side request/response bundle of the SRAM controller.
interface sram_async_ctrl_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_async_ctrl_seg7.sv
// Hex nibble to active-low seven-segment decoder (built only with SRAM_CTRL_SEG7_EN).
`ifdef SRAM_CTRL_SEG7_EN
module seg7_decoder
   import sram_async_ctrl_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_segments
);
   assign o_segments = seg7_pattern(i_nibble);
endmodule
`endif

// File: rtl/sram_async_ctrl.sv
// Asynchronous SRAM controller: single accesses with programmable WE#/OE# wait states.
// Optional SRAM_CTRL_SEG7_EN adds seven-segment views of the last address and data nibbles.
module sram_async_ctrl
   import sram_async_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 18,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned WR_WAIT = 2,
   parameter int unsigned RD_WAIT = 2,
   parameter int unsigned TURN    = 1
) (
   input  logic              clock,
   input  logic              reset,
   sram_async_ctrl_if.slave  req,
   output logic [ADDR_W-1:0] sram_address,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   output logic              sram_oe_n
`ifdef SRAM_CTRL_SEG7_EN
   ,
   output logic [6:0]        address_7_segm,
   output logic [6:0]        data_out_7_segm
`endif
);

   localparam int unsigned CNT_W = $clog2(max3(WR_WAIT, RD_WAIT, TURN) + 1);
   localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
   localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic              w_accept;
   logic              w_rd_done;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rsp_valid;
   logic              r_ce_n, r_we_n, r_oe_n;
   logic              r_drive;

   assign w_accept  = (r_state == ST_IDLE) && req.req_valid;
   assign w_rd_done = (r_state == ST_READ) && (r_cnt == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next     = req.req_write ? ST_WRITE : ST_READ;
               w_cnt_next = req.req_write ? WR_LOAD : RD_LOAD;
            end
         end
         ST_WRITE: begin
            if (r_cnt == '0) begin
               w_next     = ST_WR_HOLD;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         ST_WR_HOLD, ST_READ: begin
            if (r_state == ST_WR_HOLD || r_cnt == '0) begin
               w_next     = (TURN == 0) ? ST_IDLE : ST_TURN;
               w_cnt_next = TURN_LOAD;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         ST_TURN: begin
            if (r_cnt == '0) begin
               w_next     = ST_IDLE;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_next     = ST_IDLE;
            w_cnt_next = '0;
         end
      endcase
   end

   // Pin controls are registered from the next state so they change cleanly on the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_ce_n      <= STROBE_OFF;
         r_we_n      <= STROBE_OFF;
         r_oe_n      <= STROBE_OFF;
         r_drive     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= req.req_addr;
            r_wdata <= req.req_wdata;
         end
         r_ce_n      <= !(w_next inside {ST_WRITE, ST_WR_HOLD, ST_READ});
         r_we_n      <= (w_next != ST_WRITE);
         r_oe_n      <= (w_next != ST_READ);
         r_drive     <= (w_next inside {ST_WRITE, ST_WR_HOLD});
         r_rsp_valid <= w_rd_done;
         if (w_rd_done) begin
            r_rdata <= sram_data;
         end
      end
   end

   assign req.req_ready = (r_state == ST_IDLE);
   assign req.rsp_valid = r_rsp_valid;
   assign req.rsp_rdata = r_rdata;
   assign sram_address  = r_addr;
   assign sram_ce_n     = r_ce_n;
   assign sram_we_n     = r_we_n;
   assign sram_oe_n     = r_oe_n;
   assign sram_data     = r_drive ? r_wdata : {DATA_W{1'bz}};

`ifdef SRAM_CTRL_SEG7_EN
   logic [3:0] r_addr_nib, r_data_nib;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr_nib <= '0;
         r_data_nib <= '0;
      end else begin
         if (w_accept) begin
            r_addr_nib <= req.req_addr[3:0];
            if (req.req_write) begin
               r_data_nib <= req.req_wdata[3:0];
            end
         end
         if (w_rd_done) begin
            r_data_nib <= sram_data[3:0];
         end
      end
   end

   seg7_decoder u_seg_addr (.i_nibble(r_addr_nib), .o_segments(address_7_segm));
   seg7_decoder u_seg_data (.i_nibble(r_data_nib), .o_segments(data_out_7_segm));
`endif

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Self-checking bench for sram_async_ctrl with a behavioural asynchronous SRAM on the pins.
module tb_sram_async_ctrl;

   localparam int unsigned ADDR_W  = 18;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned WR_WAIT = 2;
   localparam int unsigned RD_WAIT = 2;
   localparam int unsigned TURN    = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sram_async_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   wire  [DATA_W-1:0] sram_data;
   logic [ADDR_W-1:0] sram_address;
   logic              sram_ce_n, sram_we_n, sram_oe_n;
`ifdef SRAM_CTRL_SEG7_EN
   logic [6:0]        address_7_segm, data_out_7_segm;
`endif

   sram_async_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .WR_WAIT(WR_WAIT), .RD_WAIT(RD_WAIT), .TURN(TURN)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req(bus),
      .sram_address(sram_address),
      .sram_data(sram_data),
      .sram_ce_n(sram_ce_n),
      .sram_we_n(sram_we_n),
      .sram_oe_n(sram_oe_n)
`ifdef SRAM_CTRL_SEG7_EN
      ,
      .address_7_segm(address_7_segm),
      .data_out_7_segm(data_out_7_segm)
`endif
   );

   // SRAM model: drives read data while selected with OE# low; while deselected it
   // drives a probe word so any leftover controller drive corrupts the bus value.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] probe;
   logic              tb_en;
   logic [DATA_W-1:0] tb_val;

   always_comb begin
      tb_en  = 1'b0;
      tb_val = probe;
      if (sram_ce_n) begin
         tb_en  = 1'b1;
         tb_val = probe;
      end else if (!sram_oe_n) begin
         tb_en  = 1'b1;
         tb_val = mem[sram_address];
      end
   end
   assign sram_data = tb_en ? tb_val : {DATA_W{1'bz}};

   always @(posedge clock) begin
      if (!sram_ce_n && !sram_we_n) mem[sram_address] <= sram_data;
   end

   // Reference: the last value written to each address.
   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   logic [ADDR_W-1:0] written_q [$];

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called and returns at a negedge. rst_at>0 asserts reset in that cycle after accept.
   task automatic access(input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit hold, input int rst_at);
      int n, we_low, oe_low, busy, rsp_cnt, rsp_at;
      bit done;
      logic [DATA_W-1:0] exp_rd;
      n = 0; we_low = 0; oe_low = 0; busy = 0; rsp_cnt = 0; rsp_at = 0; done = 1'b0;
      exp_rd = (!wr && ref_mem.exists(a)) ? ref_mem[a] : '0;
      probe = wr ? ~d : DATA_W'($urandom);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      while (!bus.req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 1 && !hold) bus.req_valid = 1'b0;
         if (!sram_we_n) we_low++;
         if (!sram_oe_n) oe_low++;
         check("we_oe_overlap", 32'(!sram_we_n && !sram_oe_n), 32'd0);
         if (!sram_ce_n) check("addr_stable", 32'(sram_address), 32'(a));
         if (sram_ce_n)      check("bus_released", 32'(sram_data), 32'(probe));
         else if (wr)        check("bus_wdata", 32'(sram_data), 32'(d));
         else                check("bus_rdata", 32'(sram_data), 32'(exp_rd));
         if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_at = k;
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
         end
         if (k == rst_at) begin
            check("we_low_before_rst", 32'(sram_we_n), 32'd0);
            reset = 1'b1;
            bus.req_valid = 1'b0;
            @(negedge clock);
            check("rst_ce_n", 32'(sram_ce_n), 32'd1);
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_oe_n", 32'(sram_oe_n), 32'd1);
            check("rst_bus_z", 32'(sram_data), 32'(probe));
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_ready", 32'(bus.req_ready), 32'd1);
            reset = 1'b0;
            return;
         end
         if (bus.req_ready) begin
            done = 1'b1;
            break;
         end
         busy++;
      end
      check("complete", 32'(done), 32'd1);
      if (wr) begin
         check("wr_we_cycles", 32'(we_low), 32'(WR_WAIT));
         check("wr_oe_cycles", 32'(oe_low), 32'd0);
         check("wr_busy", 32'(busy), 32'(WR_WAIT + 1 + TURN));
         check("wr_no_rsp", 32'(rsp_cnt), 32'd0);
         check("sram_stored", 32'(mem[a]), 32'(d));
         ref_mem[a] = d;
         written_q.push_back(a);
      end else begin
         check("rd_oe_cycles", 32'(oe_low), 32'(RD_WAIT));
         check("rd_we_cycles", 32'(we_low), 32'd0);
         check("rd_busy", 32'(busy), 32'(RD_WAIT + TURN));
         check("rd_rsp_count", 32'(rsp_cnt), 32'd1);
         check("rd_rsp_cycle", 32'(rsp_at), 32'(RD_WAIT + 1));
         check("rd_rdata_hold", 32'(bus.rsp_rdata), 32'(exp_rd));
      end
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      bit                wr, hd;
      reset = 1'b1;
      probe = 16'h3C5A;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset held three cycles while idle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("reset_ce_n", 32'(sram_ce_n), 32'd1);
         check("reset_we_n", 32'(sram_we_n), 32'd1);
         check("reset_oe_n", 32'(sram_oe_n), 32'd1);
         check("reset_bus_z", 32'(sram_data), 32'(probe));
         check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_ready", 32'(bus.req_ready), 32'd1);
      check("post_reset_addr", 32'(sram_address), 32'd0);
      check("post_reset_rdata", 32'(bus.rsp_rdata), 32'd0);
`ifdef SRAM_CTRL_SEG7_EN
      check("seg_addr_reset", 32'(address_7_segm), 32'(7'b1000000));
      check("seg_data_reset", 32'(data_out_7_segm), 32'(7'b1000000));
`endif

      // Directed write and read-back.
      access(1'b1, 18'h00005, 16'hA5C3, 1'b0, 0);
      access(1'b0, 18'h00005, 16'h0000, 1'b0, 0);

      // Valid held high through a write followed by a read.
      access(1'b1, 18'h00012, 16'h1234, 1'b1, 0);
      access(1'b0, 18'h00012, 16'h0000, 1'b0, 0);

      // Reset on the second WE# cycle of a write.
      access(1'b1, 18'h2AAAA, 16'hBEEF, 1'b0, 2);
      @(negedge clock);
      check("after_rst_ready", 32'(bus.req_ready), 32'd1);

      // Top address, and the display view of the result.
      access(1'b1, 18'h3FFFF, 16'h0007, 1'b0, 0);
      access(1'b0, 18'h3FFFF, 16'h0000, 1'b0, 0);
`ifdef SRAM_CTRL_SEG7_EN
      check("seg_addr_F", 32'(address_7_segm), 32'(7'b0001110));
      check("seg_data_7", 32'(data_out_7_segm), 32'(7'b1111000));
`endif

      // Random mix against the reference.
      for (int i = 0; i < 30; i++) begin
         wr = ($urandom_range(0, 1) == 1) || (written_q.size() == 0);
         hd = (i != 29) && ($urandom_range(0, 1) == 1);
         if (wr) begin
            ra = ADDR_W'($urandom_range(0, 255));
            access(1'b1, ra, DATA_W'($urandom), hd, 0);
         end else begin
            ra = written_q[$urandom_range(0, written_q.size() - 1)];
            access(1'b0, ra, '0, hd, 0);
         end
      end
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
